// File: rtl/mp_arb_pkg.sv
// Shared types and encodings for the multi-port memory arbiter.
package mp_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Arbitration policy selected by the RR_MODE parameter
  localparam int unsigned RR_MODE_FIXED       = 0;
  localparam int unsigned RR_MODE_ROUND_ROBIN = 1;

endpackage

// File: rtl/multi_port_arbiter_rr_select.sv
// Combinational grant picker: the first pending port at or after a start index.
// In fixed-priority mode the start index is forced to 0, so port 0 is highest.
module rr_select #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     rr_ptr,
  input  logic                 mode,
  output logic [IDX_W-1:0]     grant,
  output logic                 valid
);

  int unsigned start_idx;

  // Scan downward from the farthest candidate so the nearest pending port wins
  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    start_idx = mode ? int'(rr_ptr) : 0;
    for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
      if (pending[IDX_W'((start_idx + int'(k)) % NUM_PORTS)]) begin
        grant = IDX_W'((start_idx + int'(k)) % NUM_PORTS);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_port_arbiter.sv
// Arbitrates cacheline read/write requests from several caches onto one
// memory adaptor. One transaction at a time; the request is captured into
// registers at grant so the adaptor side never sees a combinational path
// from the requesters.
module multi_port_arbiter
  import mp_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned RR_MODE    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            req_read,
  input  logic [NUM_PORTS-1:0]            req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]           req_rdata,
  input  logic                            pmem_resp,
  input  logic [LINE_WIDTH-1:0]           pmem_rdata,
  output logic                            pmem_read,
  output logic                            pmem_write,
  output logic [ADDR_WIDTH-1:0]           pmem_address,
  output logic [LINE_WIDTH-1:0]           pmem_wdata,
  output logic [$clog2(NUM_PORTS)-1:0]    owner
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  state_t                 state;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       next_ptr;
  logic [NUM_PORTS-1:0]   pending;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;
  logic                   mode_rr;
  logic [ADDR_WIDTH-1:0]  addr_arr  [NUM_PORTS];
  logic [LINE_WIDTH-1:0]  wdata_arr [NUM_PORTS];

  assign pending  = req_read | req_write;
  assign mode_rr  = (RR_MODE == RR_MODE_ROUND_ROBIN);
  assign next_ptr = (owner == IDX_W'(NUM_PORTS - 1)) ? '0 : owner + IDX_W'(1);

  // Unpack the flat per-port buses into indexable arrays
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[i] = req_wdata[i*LINE_WIDTH +: LINE_WIDTH];
  end

  rr_select #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_rr_select (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .mode    (mode_rr),
    .grant   (sel_idx),
    .valid   (sel_valid)
  );

  // Arbitration FSM: capture the winner in IDLE, hold the op until the adaptor completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            owner        <= sel_idx;
            pmem_address <= addr_arr[sel_idx];
            pmem_wdata   <= wdata_arr[sel_idx];
            // A simultaneous read+write from one port issues only the write
            pmem_write   <= req_write[sel_idx];
            pmem_read    <= ~req_write[sel_idx];
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Return to IDLE for one cycle so the served cache can drop its request
          if (pmem_resp) begin
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            rr_ptr     <= next_ptr;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is forwarded in the same cycle to the owning port only
  always_comb begin
    req_resp  = '0;
    req_rdata = '0;
    if (state == BUSY && pmem_resp) begin
      req_resp[owner] = 1'b1;
      req_rdata       = pmem_rdata;
    end
  end

endmodule

// File: tb/tb_multi_port_arbiter.sv
// Scoreboard bench for multi_port_arbiter: one round-robin and one
// fixed-priority instance share stimulus; `sel` picks which one is observed.
module tb_multi_port_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;

  typedef struct {
    int              port;
    bit              wr;
    logic [AW-1:0]   addr;
    logic [LW-1:0]   wdata;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     req_read;
  logic [NP-1:0]     req_write;
  logic [NP*AW-1:0]  req_addr;
  logic [NP*LW-1:0]  req_wdata;
  logic              pmem_resp;
  logic [LW-1:0]     pmem_rdata;

  logic [NP-1:0]     rr_resp,  fp_resp,  obs_resp;
  logic [LW-1:0]     rr_rdata, fp_rdata, obs_rdata;
  logic              rr_read,  fp_read,  obs_read;
  logic              rr_write, fp_write, obs_write;
  logic [AW-1:0]     rr_addr,  fp_addr,  obs_addr;
  logic [LW-1:0]     rr_wdata, fp_wdata, obs_wdata;
  logic [1:0]        rr_owner, fp_owner, obs_owner;
  logic              sel;

  exp_t              sb[$];
  logic [LW-1:0]     port_line [NP];
  int                n_tests = 0;
  int                n_fail  = 0;

  always #5 clk = ~clk;

  multi_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_resp(rr_resp), .req_rdata(rr_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pmem_read(rr_read), .pmem_write(rr_write),
    .pmem_address(rr_addr), .pmem_wdata(rr_wdata), .owner(rr_owner));

  multi_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_resp(fp_resp), .req_rdata(fp_rdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .pmem_read(fp_read), .pmem_write(fp_write),
    .pmem_address(fp_addr), .pmem_wdata(fp_wdata), .owner(fp_owner));

  assign obs_resp  = sel ? fp_resp  : rr_resp;
  assign obs_rdata = sel ? fp_rdata : rr_rdata;
  assign obs_read  = sel ? fp_read  : rr_read;
  assign obs_write = sel ? fp_write : rr_write;
  assign obs_addr  = sel ? fp_addr  : rr_addr;
  assign obs_wdata = sel ? fp_wdata : rr_wdata;
  assign obs_owner = sel ? fp_owner : rr_owner;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int p, input bit rd, input bit wr, input logic [AW-1:0] a);
    req_read[p]            = rd;
    req_write[p]           = wr;
    req_addr[p*AW +: AW]   = a;
    req_wdata[p*LW +: LW]  = port_line[p];
  endtask

  task automatic clear_reqs();
    req_read  = '0;
    req_write = '0;
  endtask

  task automatic push_exp(input int p, input bit wr, input logic [AW-1:0] a);
    exp_t e;
    e.port  = p;
    e.wr    = wr;
    e.addr  = a;
    e.wdata = port_line[p];
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
  endtask

  // Wait for the next adaptor op, compare against the scoreboard head, then complete it
  task automatic serve(input logic [LW-1:0] line);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = obs_read | obs_write;
    end
    check("op_timeout", seen, 1);
    if (!seen) return;
    check("owner", obs_owner, e.port);
    check("pmem_write", obs_write, e.wr);
    check("pmem_read", obs_read, !e.wr);
    check("pmem_address", obs_addr, e.addr);
    if (e.wr) check("pmem_wdata", obs_wdata, e.wdata);
    @(negedge clk);
    check("op_hold", {obs_read, obs_write}, {!e.wr, e.wr});
    check("resp_before_done", obs_resp, 0);
    @(posedge clk); #1;
    pmem_resp  = 1'b1;
    pmem_rdata = line;
    @(negedge clk);
    check("req_resp", obs_resp, NP'(1) << e.port);
    check("req_rdata", obs_rdata, line);
    @(posedge clk); #1;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    check("idle_gap", {obs_read, obs_write}, 0);
    check("resp_clear", obs_resp, 0);
    check("rdata_zero", obs_rdata, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel        = 1'b0;
    rst        = 1'b0;
    req_read   = '0;
    req_write  = '0;
    req_addr   = '0;
    req_wdata  = '0;
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    for (int i = 0; i < int'(NP); i++)
      port_line[i] = {8{$urandom()}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read", obs_read, 0);
    check("rst_write", obs_write, 0);
    check("rst_addr", obs_addr, 0);
    check("rst_wdata", obs_wdata, 0);
    check("rst_owner", obs_owner, 0);
    check("rst_resp", obs_resp, 0);
    check("rst_rdata", obs_rdata, 0);
    @(posedge clk); #1 rst = 1'b1;

    // Single read from port 2 with latency check
    @(posedge clk); #1;
    set_req(2, 1'b1, 1'b0, 32'h0000_1000);
    push_exp(2, 1'b0, 32'h0000_1000);
    @(negedge clk);
    check("lat_t", obs_read, 0);
    @(negedge clk);
    check("lat_t1", obs_read, 1);
    serve({32{8'hAB}});
    clear_reqs();

    // Stray response in IDLE
    @(posedge clk); #1 pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}};
    @(negedge clk);
    check("stray_resp", obs_resp, 0);
    check("stray_rdata", obs_rdata, 0);
    @(posedge clk); #1 pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    check("stray_idle", {obs_read, obs_write}, 0);

    // Round-robin with all ports continuously requesting
    pulse_reset();
    for (int i = 0; i < int'(NP); i++)
      set_req(i, 1'b1, 1'b0, 32'h1000 + 32'(i) * 32'h40);
    for (int k = 0; k < 5; k++)
      push_exp(k % 4, 1'b0, 32'h1000 + 32'(k % 4) * 32'h40);
    for (int k = 0; k < 5; k++)
      serve({8{$urandom()}});
    clear_reqs();

    // Read+write collision on port 0 issues the write
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h40);
    push_exp(0, 1'b1, 32'h40);
    serve({8{32'h1234_5678}});
    clear_reqs();

    // Port 3 drops its request while busy; completion still pulses
    @(posedge clk); #1;
    set_req(3, 1'b1, 1'b0, 32'h300);
    push_exp(3, 1'b0, 32'h300);
    @(posedge clk); #1;
    clear_reqs();
    serve({8{32'h0BAD_F00D}});

    // Reset two cycles after grant abandons the transaction
    @(posedge clk); #1;
    set_req(2, 1'b1, 1'b0, 32'h2000);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_rst_busy", obs_read, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_read", obs_read, 0);
    check("mid_rst_write", obs_write, 0);
    check("mid_rst_owner", obs_owner, 0);
    check("mid_rst_addr", obs_addr, 0);
    check("mid_rst_wdata", obs_wdata, 0);
    clear_reqs();
    pmem_resp  = 1'b1;
    pmem_rdata = {8{32'h5555_AAAA}};
    @(negedge clk);
    check("mid_rst_resp", obs_resp, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post_rst_resp", obs_resp, 0);
    check("post_rst_rdata", obs_rdata, 0);
    @(posedge clk); #1 pmem_resp = 1'b0; pmem_rdata = '0;
    set_req(2, 1'b1, 1'b0, 32'h2000);
    set_req(0, 1'b1, 1'b0, 32'h0800);
    push_exp(0, 1'b0, 32'h0800);
    serve({8{32'hCAFE_0001}});
    clear_reqs();

    // Fixed priority: port 1 always beats port 3
    pulse_reset();
    sel = 1'b1;
    set_req(1, 1'b1, 1'b0, 32'h0100);
    set_req(3, 1'b0, 1'b1, 32'h0300);
    for (int k = 0; k < 3; k++)
      push_exp(1, 1'b0, 32'h0100);
    for (int k = 0; k < 3; k++)
      serve({8{$urandom()}});
    clear_reqs();

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_port_arbiter.md
MULTI_PORT_ARBITER -- requirements
Module: multi_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of requesting caches, range 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: memory address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 256: cacheline width.
REQ-004 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with port 0 highest.
REQ-005 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous and active-low (0 = reset).
REQ-007 SHALL have port req_read  in  NUM_PORTS  per-port line read request.
REQ-008 SHALL have port req_write  in  NUM_PORTS  per-port line write request.
REQ-009 SHALL have port req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice i.
REQ-010 SHALL have port req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port write line; port i occupies slice i.
REQ-011 SHALL have port req_resp  out  NUM_PORTS  per-port completion pulse.
REQ-012 SHALL have port req_rdata  out  LINE_WIDTH  read line, valid only with a req_resp bit.
REQ-013 SHALL have port pmem_resp  in  1  adaptor completion.
REQ-014 SHALL have port pmem_rdata  in  LINE_WIDTH  adaptor read line.
REQ-015 SHALL have port pmem_read  out  1  read to adaptor.
REQ-016 SHALL have port pmem_write  out  1  write to adaptor.
REQ-017 SHALL have port pmem_address  out  ADDR_WIDTH  address to adaptor.
REQ-018 SHALL have port pmem_wdata  out  LINE_WIDTH  write line to adaptor.
REQ-019 SHALL have port owner  out  $clog2(NUM_PORTS)  index of the granted port; debug only.

Function
REQ-020 SHALL implement FSM states IDLE and BUSY.
REQ-021 In IDLE, a port is pending if req_read[i] or req_write[i] is high; any pending port SHALL cause a grant and a transition to BUSY next cycle.
REQ-022 Grant selection SHALL be fixed priority (lowest index) when RR_MODE=0.
REQ-023 When RR_MODE=1, grant selection SHALL pick the first pending port at or after rr_ptr, wrapping from NUM_PORTS-1 to 0.
REQ-024 At grant, the arbiter SHALL register owner, address, wdata and op; pmem_* SHALL be driven only from these registers (no combinational path req_* -> pmem_*).
REQ-025 Latency: a request first seen in IDLE at cycle t SHALL produce pmem_read/pmem_write high at t+1.
REQ-026 If a port asserts read and write together, the write SHALL be issued and the read ignored.
REQ-027 In BUSY, pmem_read/pmem_write SHALL be held constant until pmem_resp.
REQ-028 In a cycle where pmem_resp=1 in BUSY: req_resp[owner]=1 combinationally, req_rdata=pmem_rdata, and all other req_resp bits=0.
REQ-029 On the same edge as REQ-028, the FSM SHALL go to IDLE, pmem_read/pmem_write SHALL clear, and rr_ptr SHALL become (owner+1) mod NUM_PORTS.
REQ-030 The mandatory IDLE cycle after each completion SHALL let the served cache drop its request before re-arbitration.
REQ-031 A requester that drops its request while BUSY SHALL not abort the transaction; its req_resp SHALL still pulse.
REQ-032 pmem_resp while in IDLE SHALL be ignored; no req_resp bit asserts.
REQ-033 req_rdata SHALL be 0 whenever no req_resp bit is high.
REQ-034 Round-robin SHALL bound the wait: a continuously pending port is granted within NUM_PORTS transactions.

Reset
REQ-035 rst=0 SHALL asynchronously force: state IDLE, rr_ptr 0, owner 0, pmem_read 0, pmem_write 0, pmem_address 0, pmem_wdata 0, req_resp 0, req_rdata 0.
REQ-036 A reset during BUSY SHALL abandon the transaction with no req_resp for it.
REQ-037 After release of rst, arbitration SHALL restart from port 0.

Structure
REQ-038 Package mp_arb_pkg SHALL hold the state enum (IDLE, BUSY) and the RR_MODE encodings.
REQ-039 Sub-module rr_select (combinational; inputs pending vector, rr_ptr, mode; outputs grant index and valid) SHALL implement REQ-022/023.

Verification (NUM_PORTS=4, RR_MODE=1 unless noted)
REQ-040 Single read: port 2 reads 0x0000_1000 at t -> pmem_read=1 with address 0x1000 at t+1; pmem_resp with line 0xAB.. -> req_resp=4'b0100 and req_rdata=0xAB.. in that cycle.
REQ-041 Round-robin: all 4 ports request continuously -> grant order 0,1,2,3,0, with one IDLE cycle between transactions.
REQ-042 Fixed priority (RR_MODE=0): ports 1 and 3 request continuously -> port 1 granted every time and port 3 never.
REQ-043 Read+write collision: port 0 asserts both with address 0x40 -> pmem_write=1, pmem_read=0, pmem_wdata equals port 0's line.
REQ-044 Reset mid-op: rst=0 two cycles after grant -> all outputs 0 immediately; a later pmem_resp produces no req_resp; next grant goes to port 0.
REQ-045 Stray response: pmem_resp=1 in IDLE -> req_resp stays 4'b0000 and state stays IDLE.
